// File: rtl/load_store_unit_if.sv
// Signal bundle between the load/store unit and its neighbours: pipeline
// request, data bus, external shifter and writeback response.
// Ports: master = the load/store unit itself; slave = the surrounding system.
interface load_store_unit_if;
  // pipeline request
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [4:0]  req_rd;
  // word-aligned data bus
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // external shifter
  logic [31:0] sh_op;
  logic [4:0]  sh_amt;
  logic [4:0]  sh_maskbits;
  logic        sh_left;
  logic        sh_sx;
  logic [31:0] sh_out;
  // writeback response
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  modport master (
    input  req_valid, req_addr, req_wdata, req_store, req_size, req_signed, req_rd,
    output req_ready,
    output mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output sh_op, sh_amt, sh_maskbits, sh_left, sh_sx,
    input  sh_out,
    output rsp_valid, rsp_data, rsp_rd, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_store, req_size, req_signed, req_rd,
    input  req_ready,
    input  mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  sh_op, sh_amt, sh_maskbits, sh_left, sh_sx,
    output sh_out,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores, extracts/sign-extends
// loads through the external shifter, flags misaligned/reserved accesses.
// Ports: clk, rst (sync, active high), bus (load_store_unit_if.master).
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ALIGN, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0] addr_q, wdata_q, rbuf_q, rsp_data_q;
  logic [1:0]  size_q;
  logic [4:0]  rd_q;
  logic        store_q, signed_q, rsp_err_q;
  logic [1:0]  off;
  logic        req_err;
  logic [3:0]  strb;

  assign off = addr_q[1:0];

  // Decoded from the live request so the error is captured at accept time.
  always_comb begin
    req_err = 1'b0;
    unique case (bus.req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = bus.req_addr[0];
      2'd2:    req_err = (bus.req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    strb = 4'h0;
    unique case (size_q)
      2'd0:    strb = 4'b0001 << off;
      2'd1:    strb = 4'b0011 << off;
      default: strb = 4'hF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = 32'h0;
    bus.mem_we      = 1'b0;
    bus.mem_wstrb   = 4'h0;
    bus.mem_wdata   = 32'h0;
    bus.sh_op       = 32'h0;
    bus.sh_amt      = 5'd0;
    bus.sh_maskbits = 5'd0;
    bus.sh_left     = 1'b0;
    bus.sh_sx       = 1'b0;
    bus.rsp_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid && !rst) state_nxt = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_we    = store_q;
        if (store_q) begin
          bus.mem_wstrb = strb;
          bus.sh_op     = wdata_q;
          bus.sh_amt    = {off, 3'b000};
          bus.sh_left   = 1'b1;
          bus.mem_wdata = bus.sh_out;
        end
        if (bus.mem_ready) state_nxt = store_q ? RESP : WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) state_nxt = ALIGN;
      end
      ALIGN: begin
        bus.sh_op  = rbuf_q;
        bus.sh_amt = {off, 3'b000};
        // Keep only the accessed lane after the right shift.
        bus.sh_maskbits = (size_q == 2'd0) ? 5'd24 : (size_q == 2'd1) ? 5'd16 : 5'd0;
        bus.sh_sx       = signed_q && (size_q != 2'd2);
        state_nxt       = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= 2'd0;
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      rd_q       <= 5'd0;
      rbuf_q     <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        size_q     <= bus.req_size;
        store_q    <= bus.req_store;
        signed_q   <= bus.req_signed;
        rd_q       <= bus.req_rd;
        // Stores and errors respond with zero data; loads overwrite in ALIGN.
        rsp_data_q <= 32'h0;
        rsp_err_q  <= req_err;
      end
      if (state == WAIT && bus.mem_rvalid) rbuf_q <= bus.mem_rdata;
      if (state == ALIGN) rsp_data_q <= bus.sh_out;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_rd   = rd_q;
  assign bus.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference shifter: shift, keep the low (32-maskbits) bits, optionally sign-extend.
  logic [31:0] shf, keep;
  always_comb begin
    shf = bus.sh_left ? (bus.sh_op << bus.sh_amt) : (bus.sh_op >> bus.sh_amt);
    keep = 32'hFFFF_FFFF >> bus.sh_maskbits;
    bus.sh_out = shf & keep;
    if (bus.sh_sx && shf[5'd31 - bus.sh_maskbits]) bus.sh_out = shf | ~keep;
  end

  int n_vec = 0, n_bad = 0;
  int cyc = 0, mv_cnt = 0, rsp_cnt = 0;
  logic auto_rv = 1'b1;
  logic [31:0] rdata_q = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; memory model returns read data the cycle after a load command.
  task automatic step();
    logic fire_rd;
    fire_rd = bus.mem_valid && bus.mem_ready && !bus.mem_we && !rst;
    if (bus.mem_valid) mv_cnt++;
    if (bus.rsp_valid && bus.rsp_ready) rsp_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_rvalid = fire_rd && auto_rv;
    bus.mem_rdata  = rdata_q;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic st,
                      input logic [1:0] sz, input logic sg, input logic [4:0] rd,
                      output int acc);
    bus.req_addr = a; bus.req_wdata = wd; bus.req_store = st;
    bus.req_size = sz; bus.req_signed = sg; bus.req_rd = rd;
    bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        acc = cyc;
        step();
        break;
      end
      step();
    end
    bus.req_valid = 1'b0;
    check_eq("accept", 32'(acc >= 0), 32'd1);
  endtask

  task automatic wait_rsp(input int acc, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        lat = cyc - acc;
        break;
      end
      step();
    end
  endtask

  // Full load with a prompt bus; checks latency, data, tag, error and re-arm.
  task automatic load_case(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] rdat, input logic [4:0] rd,
                           input logic [31:0] exp);
    int acc, lat;
    rdata_q = rdat;
    send(a, 32'h0, 1'b0, sz, sg, rd, acc);
    wait_rsp(acc, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq({tag, "_data"}, bus.rsp_data, exp);
    check_eq({tag, "_rd"}, 32'(bus.rsp_rd), 32'(rd));
    check_eq({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    step();
    check_eq({tag, "_rearm"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int acc, lat, mv0, r0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.req_store = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0; bus.req_rd = 5'd0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus.rsp_ready = 1'b1;
    step(); step();

    // reset state
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'h0);
    check_eq("rst_sh_op", bus.sh_op, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // load byte, with a look at the command cycle
    rdata_q = 32'h80AABBCC;
    send(32'h1003, 32'h0, 1'b0, 2'd0, 1'b1, 5'd3, acc);
    check_eq("lb_mem_valid", 32'(bus.mem_valid), 32'd1);
    check_eq("lb_mem_addr", bus.mem_addr, 32'h1000);
    check_eq("lb_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("lb_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check_eq("lb_sh_idle", bus.sh_op, 32'h0);
    wait_rsp(acc, lat);
    check_eq("lb_lat", 32'(lat), 32'd4);
    check_eq("lb_data", bus.rsp_data, 32'hFFFFFF80);
    check_eq("lb_err", 32'(bus.rsp_err), 32'd0);
    check_eq("lb_rd", 32'(bus.rsp_rd), 32'd3);
    step();
    check_eq("lb_rearm", 32'(bus.req_ready), 32'd1);

    load_case("lhu", 32'h1002, 2'd1, 1'b0, 32'h80AABBCC, 5'd4, 32'h000080AA);
    load_case("lh",  32'h1002, 2'd1, 1'b1, 32'h80AABBCC, 5'd5, 32'hFFFF80AA);
    load_case("lbu0", 32'h1000, 2'd0, 1'b0, 32'h80AABBCC, 5'd6, 32'h000000CC);

    // store byte
    send(32'h2001, 32'h000000EE, 1'b1, 2'd0, 1'b0, 5'd8, acc);
    check_eq("sb_mem_addr", bus.mem_addr, 32'h2000);
    check_eq("sb_mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("sb_mem_wstrb", 32'(bus.mem_wstrb), 32'b0010);
    check_eq("sb_mem_wdata", 32'(bus.mem_wdata[15:8]), 32'hEE);
    wait_rsp(acc, lat);
    check_eq("sb_lat", 32'(lat), 32'd2);
    check_eq("sb_data", bus.rsp_data, 32'h0);
    check_eq("sb_err", 32'(bus.rsp_err), 32'd0);
    step();

    // misaligned word and half: error after one cycle, no bus activity
    mv0 = mv_cnt;
    send(32'h3002, 32'h0, 1'b0, 2'd2, 1'b0, 5'd10, acc);
    wait_rsp(acc, lat);
    check_eq("lw_mis_lat", 32'(lat), 32'd1);
    check_eq("lw_mis_err", 32'(bus.rsp_err), 32'd1);
    check_eq("lw_mis_data", bus.rsp_data, 32'h0);
    step();
    send(32'h3001, 32'h0, 1'b1, 2'd1, 1'b0, 5'd11, acc);
    wait_rsp(acc, lat);
    check_eq("sh_mis_lat", 32'(lat), 32'd1);
    check_eq("sh_mis_err", 32'(bus.rsp_err), 32'd1);
    step();
    check_eq("mis_no_bus", 32'(mv_cnt - mv0), 32'd0);

    // stalls: command held 5 cycles, response held 3 cycles
    r0 = rsp_cnt;
    bus.mem_ready = 1'b0;
    send(32'h4000, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 5'd12, acc);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_mem_valid", 32'(bus.mem_valid), 32'd1);
      check_eq("stall_mem_addr", bus.mem_addr, 32'h4000);
      check_eq("stall_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
      check_eq("stall_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      check_eq("stall_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.mem_ready = 1'b1;
    bus.rsp_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("stall_rsp_data", bus.rsp_data, 32'h0);
      check_eq("stall_rsp_rd", 32'(bus.rsp_rd), 32'd12);
      check_eq("stall_rsp_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    check_eq("stall_rearm", 32'(bus.req_ready), 32'd1);
    step(); step();
    check_eq("stall_one_rsp", 32'(rsp_cnt - r0), 32'd1);

    // reset while waiting for read data, then a late return
    auto_rv = 1'b0;
    send(32'h5000, 32'h0, 1'b0, 2'd2, 1'b0, 5'd7, acc);
    step();
    check_eq("wait_mem_valid", 32'(bus.mem_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_mid_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    r0 = rsp_cnt;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    step();
    for (int i = 0; i < 4; i++) step();
    check_eq("rst_mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check_eq("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    auto_rv = 1'b1;
    load_case("lw_after_rst", 32'h6000, 2'd2, 1'b1, 32'h12345678, 5'd9, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
